rom_read_arbiter: RTL

- Shares one synchronous-read port of the 32-bit instruction/data ROM between NUM_REQ requesters, e.g. CPU data loads, video/sprite fetch and the boot loader.
- Round-robin arbitration, one grant per cycle, with an optional per-requester lock for back-to-back bursts.
- Sits between the requesters and one ROM address/data port pair. The ROM registers its read data, so read latency is 1 cycle.

---
 rtl/rom_read_arbiter_if.sv | 37 +++
 rtl/rom_read_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : rom_read_arbiter_if
// Description : Bundle between the ROM read requesters and the arbiter, which
//               also carries the single ROM address/data port pair.
//                 req_valid/req_lock/req_addr : requester -> arbiter
//                 req_ready/rsp_valid/rsp_data: arbiter -> requesters
//                 rom_a                       : arbiter -> ROM address
//                 rom_spo                     : ROM registered read data
//               master : requester side plus the ROM instance
//               slave  : the arbiter
// Revision    : 1.0  initial release
//==============================================================================
interface rom_read_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_REQ    = 3
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [31:0]                   rsp_data;
   logic [ADDR_WIDTH-1:0]         rom_a;
   logic [31:0]                   rom_spo;

   modport master (
      output req_valid, req_lock, req_addr, rom_spo,
      input  req_ready, rsp_valid, rsp_data, rom_a
   );

   modport slave (
      input  req_valid, req_lock, req_addr, rom_spo,
      output req_ready, rsp_valid, rsp_data, rom_a
   );
endinterface
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : rom_read_arbiter
// Description : Shares one synchronous-read ROM port (1-cycle read latency)
//               between NUM_REQ requesters. Round-robin, one grant per cycle,
//               with an optional per-requester lock for back-to-back bursts of
//               up to MAX_LOCK beats.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               bus   - rom_read_arbiter_if.slave (requests, grants,
//                       responses, ROM address/data)
// Options     : ROM_ARB_PRIO0_EN - when defined, requester 0 has strict
//               priority over the round-robin search while unlocked.
// Revision    : 1.0  initial release
//==============================================================================
module rom_read_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_REQ    = 3,
   parameter int MAX_LOCK   = 16
) (
   input wire logic          clk,
   input wire logic          rst,
   rom_read_arbiter_if.slave bus
);

   localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_CNT_W = $clog2(MAX_LOCK + 1);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("rom_read_arbiter: NUM_REQ must be in the range 2..8");
      end
      if (MAX_LOCK < 1) begin : g_bad_max_lock
         $error("rom_read_arbiter: MAX_LOCK must be at least 1");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                 r_state;
   logic [c_IDX_W-1:0]     r_ptr;       // round-robin search start
   logic [c_IDX_W-1:0]     r_owner;     // requester holding the lock
   logic [c_CNT_W-1:0]     r_cnt;       // beats granted in the current lock
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic [ADDR_WIDTH-1:0]  r_rom_a;     // last granted address

   logic                   w_gnt;
   logic [c_IDX_W-1:0]     w_gnt_idx;
   logic [c_IDX_W-1:0]     w_ptr_next;
   logic [NUM_REQ-1:0]     w_ready;
   logic [ADDR_WIDTH-1:0]  w_addr;

   // Grant selection. Gated by rst so that no grant is visible while the
   // arbiter is held in reset.
   always_comb begin
      int w_idx;
      w_idx     = 0;
      w_gnt     = 1'b0;
      w_gnt_idx = r_owner;
      if (!rst) begin
         if (r_state == ST_LOCKED) begin
            // Only the owner may be granted; a dropped request yields a bubble.
            w_gnt = bus.req_valid[r_owner];
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               w_idx = int'(r_ptr) + k;
               if (w_idx >= NUM_REQ) begin
                  w_idx = w_idx - NUM_REQ;
               end
               if (!w_gnt && bus.req_valid[w_idx]) begin
                  w_gnt     = 1'b1;
                  w_gnt_idx = c_IDX_W'(w_idx);
               end
            end
`ifdef ROM_ARB_PRIO0_EN
            if (bus.req_valid[0]) begin
               w_gnt     = 1'b1;
               w_gnt_idx = '0;
            end
`endif
         end
      end
   end

   // One-hot ready and address mux. With no grant the ROM address holds its
   // last value so the ROM input does not toggle needlessly.
   always_comb begin
      w_ready = '0;
      w_addr  = r_rom_a;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt && (c_IDX_W'(i) == w_gnt_idx)) begin
            w_ready[i] = 1'b1;
            w_addr     = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign w_ptr_next = (w_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                            : w_gnt_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= '0;
         r_rom_a     <= '0;
      end else begin
         // ROM data arrives one cycle after the grant.
         r_rsp_valid <= w_ready;
         if (w_gnt) begin
            r_rom_a <= w_addr;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_gnt) begin
`ifdef ROM_ARB_PRIO0_EN
                  // A strict-priority win by requester 0 leaves the
                  // round-robin position untouched.
                  if (!bus.req_valid[0]) begin
                     r_ptr <= w_ptr_next;
                  end
`else
                  r_ptr <= w_ptr_next;
`endif
                  // With MAX_LOCK of 1 the first beat is already the last.
                  if (bus.req_lock[w_gnt_idx] && (MAX_LOCK > 1)) begin
                     r_state <= ST_LOCKED;
                     r_owner <= w_gnt_idx;
                     r_cnt   <= c_CNT_W'(1);
                  end
               end
            end

            ST_LOCKED: begin
               if (!w_gnt) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
               end else if (!bus.req_lock[r_owner] ||
                            (r_cnt == c_CNT_W'(MAX_LOCK - 1))) begin
                  // Final beat of the burst is granted, then release.
                  r_state <= ST_IDLE;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rom_a     = w_addr;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = bus.rom_spo;

endmodule
`default_nettype wire
